// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: sizing helpers shared by the pipelined adder tree and its levels.
// All functions are constant functions, usable in parameter and port declarations.
package adder_tree_pkg;

    // Number of pairwise-add levels needed to reduce n operands to one.
    function automatic int tree_levels(input int n);
        return $clog2(n);
    endfunction

    // Full-precision width of the sum of n unsigned w-bit operands.
    function automatic int sum_width(input int w, input int n);
        return w + tree_levels(n);
    endfunction

    // Element count after l levels of pairwise reduction (ceil(n / 2^l)).
    function automatic int level_count(input int n, input int l);
        int cnt;
        cnt = n;
        for (int i = 0; i < l; i++) begin
            cnt = (cnt + 1) / 2;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level: one registered level of the adder tree.
// Adds neighbouring elements pairwise; an odd trailing element is zero-extended
// and registered unchanged. Data loads only when in_valid is set, so the level
// holds its last result through bubbles.
module adder_tree_level #(
    parameter int IN_CNT = 4,
    parameter int IN_W   = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_valid,
    input  logic [IN_CNT*IN_W-1:0]                in_data,
    output logic                                  out_valid,
    output logic [((IN_CNT+1)/2)*(IN_W+1)-1:0]    out_data
);

    localparam int OUT_CNT = (IN_CNT + 1) / 2;
    localparam int OUT_W   = IN_W + 1;

    logic [OUT_W-1:0]         next_elem [OUT_CNT];
    logic [OUT_CNT*OUT_W-1:0] data_d, data_q;
    logic                     valid_d, valid_q;

    // Pairwise sums; the last element of an odd-sized level passes through.
    for (genvar i = 0; i < OUT_CNT; i++) begin : g_elem
        if (2 * i + 1 < IN_CNT) begin : g_pair
            assign next_elem[i] = OUT_W'(in_data[2*i*IN_W +: IN_W])
                                + OUT_W'(in_data[(2*i+1)*IN_W +: IN_W]);
        end else begin : g_odd
            assign next_elem[i] = OUT_W'(in_data[2*i*IN_W +: IN_W]);
        end
    end

    // Next-state: load the new sums on a valid cycle, otherwise hold.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        data_d  = data_q;
        valid_d = in_valid;
        if (in_valid) begin
            for (int i = 0; i < OUT_CNT; i++) begin
                data_d[i*OUT_W +: OUT_W] = next_elem[i];
            end
        end
    end

    // Level registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: data registers are reset as well as the valid bit, so sum reads 0 after reset.
        if (reset) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree: registered multi-operand unsigned adder.
// Stage 0 registers the operands; LEVELS registered pairwise-add levels follow,
// so a result appears LEVELS edges after its operands were sampled. A valid bit
// rides alongside the data; each stage loads only on its incoming valid bit.
// Optional macro ACCUM_EN adds a wrapping running total (acc, acc_clear).
module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter int N_OPS = 4,
    parameter int WIDTH = 8
`ifdef ACCUM_EN
    ,
    parameter int ACC_W = 16
`endif
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                in_valid,
    input  logic [N_OPS*WIDTH-1:0]              operands,
    output logic                                out_valid,
    output logic [sum_width(WIDTH, N_OPS)-1:0]  sum
`ifdef ACCUM_EN
    ,
    input  logic                                acc_clear,
    output logic [ACC_W-1:0]                    acc
`endif
);

    localparam int LEVELS = tree_levels(N_OPS);
    localparam int SUM_W  = sum_width(WIDTH, N_OPS);

    logic [N_OPS*WIDTH-1:0] stage0_d, stage0_q;
    logic                   stage0_valid_d, stage0_valid_q;

    // Stage 0 next-state: capture operands only on a valid cycle.
    always_comb begin
        stage0_d       = stage0_q;
        stage0_valid_d = in_valid;
        if (in_valid) begin
            stage0_d = operands;
        end
    end

    // Stage 0 registers; reset wins over a coincident in_valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage0_q       <= '0;
            stage0_valid_q <= 1'b0;
        end else begin
            stage0_q       <= stage0_d;
            stage0_valid_q <= stage0_valid_d;
        end
    end

    // Tree levels 1..LEVELS; each grows one bit and halves the element count.
    for (genvar l = 1; l <= LEVELS; l++) begin : g_level
        localparam int IN_CNT  = level_count(N_OPS, l - 1);
        localparam int IN_W    = WIDTH + l - 1;
        localparam int OUT_CNT = level_count(N_OPS, l);

        logic [IN_CNT*IN_W-1:0]        lvl_in;
        logic                          lvl_in_valid;
        logic [OUT_CNT*(IN_W+1)-1:0]   lvl_out;
        logic                          lvl_out_valid;

        if (l == 1) begin : g_first
            assign lvl_in       = stage0_q;
            assign lvl_in_valid = stage0_valid_q;
        end else begin : g_rest
            assign lvl_in       = g_level[l-1].lvl_out;
            assign lvl_in_valid = g_level[l-1].lvl_out_valid;
        end

        adder_tree_level #(
            .IN_CNT (IN_CNT),
            .IN_W   (IN_W)
        ) u_level (
            .clock     (clock),
            .reset     (reset),
            .in_valid  (lvl_in_valid),
            .in_data   (lvl_in),
            .out_valid (lvl_out_valid),
            .out_data  (lvl_out)
        );
    end

    // The last level holds a single SUM_W-bit element and drives the outputs.
    assign sum       = g_level[LEVELS].lvl_out[SUM_W-1:0];
    assign out_valid = g_level[LEVELS].lvl_out_valid;

`ifdef ACCUM_EN
    logic [ACC_W-1:0] acc_d, acc_q;

    // Accumulator next-state: clear-then-add when acc_clear meets a result.
    always_comb begin
        acc_d = acc_q;
        if (acc_clear) begin
            acc_d = out_valid ? ACC_W'(sum) : '0;
        end else if (out_valid) begin
            acc_d = acc_q + ACC_W'(sum);
        end
    end

    // Accumulator register, wrapping modulo 2^ACC_W.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
`endif

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Scoreboard bench for pipelined_adder_tree: three configurations
// (4x8, 3x8, 5x6) driven together; expected sums and due edges are queued at
// issue time and checked by a negedge monitor. With ACCUM_EN the 4x8 instance
// also has its running total modelled.
module tb_pipelined_adder_tree;

    localparam int N_OF  [3] = '{4, 3, 5};
    localparam int W_OF  [3] = '{8, 8, 6};
    localparam int LV_OF [3] = '{2, 2, 3};
    localparam int ACC_W = 12;

    typedef struct {
        int sum;
        int due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        acc_clear = 1'b0;
    logic        in_valid_a = 1'b0, in_valid_b = 1'b0, in_valid_c = 1'b0;
    logic [31:0] ops_a = '0;
    logic [23:0] ops_b = '0;
    logic [29:0] ops_c = '0;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [9:0]  sum_a, sum_b;
    logic [8:0]  sum_c;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic rst_prev = 1'b1;
    logic clr_prev = 1'b0;
    exp_t q [3][$];
    int   last [3] = '{0, 0, 0};
    logic pend_ov = 1'b0;
    int   pend_sum = 0;
    int   acc_m = 0;

    always #5 clock = ~clock;

`ifdef ACCUM_EN
    logic [ACC_W-1:0] acc_a;
    pipelined_adder_tree #(.N_OPS(4), .WIDTH(8), .ACC_W(ACC_W)) dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid_a), .operands(ops_a),
        .out_valid(out_valid_a), .sum(sum_a), .acc_clear(acc_clear), .acc(acc_a));
`else
    pipelined_adder_tree #(.N_OPS(4), .WIDTH(8)) dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid_a), .operands(ops_a),
        .out_valid(out_valid_a), .sum(sum_a));
`endif

    pipelined_adder_tree #(.N_OPS(3), .WIDTH(8)) dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid_b), .operands(ops_b),
        .out_valid(out_valid_b), .sum(sum_b));

    pipelined_adder_tree #(.N_OPS(5), .WIDTH(6)) dut_c (
        .clock(clock), .reset(reset), .in_valid(in_valid_c), .operands(ops_c),
        .out_valid(out_valid_c), .sum(sum_c));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Edge counter and the control values each edge actually sampled.
    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_prev <= reset;
        clr_prev <= acc_clear;
    end

    task automatic mon(input int id, input logic ov, input logic [31:0] s);
        logic exp_v;
        int   exp_s;
        exp_v = 1'b0;
        exp_s = 0;
        if (rst_prev) begin
            q[id].delete();
            check($sformatf("reset_valid[%0d]", id), 64'(ov), 64'(0));
            check($sformatf("reset_sum[%0d]", id), 64'(s), 64'(0));
            last[id] = 0;
        end else begin
            exp_v = (q[id].size() > 0) && (q[id][0].due == cyc);
            check($sformatf("out_valid[%0d]", id), 64'(ov), 64'(exp_v));
            if (exp_v) begin
                exp_s    = q[id].pop_front().sum;
                last[id] = exp_s;
                check($sformatf("sum[%0d]", id), 64'(s), 64'(exp_s));
            end else begin
                check($sformatf("hold_sum[%0d]", id), 64'(s), 64'(last[id]));
            end
        end
        if (id == 0) begin
            pend_ov  = exp_v;
            pend_sum = exp_s;
        end
    endtask

    // Monitor: accumulator model first (uses last cycle's result), then scoreboards.
    always @(negedge clock) begin
        if (rst_prev) acc_m = 0;
        else if (clr_prev) acc_m = pend_ov ? pend_sum : 0;
        else if (pend_ov) acc_m = (acc_m + pend_sum) % (1 << ACC_W);
`ifdef ACCUM_EN
        check("acc", 64'(acc_a), 64'(acc_m));
`endif
        mon(0, out_valid_a, 32'(sum_a));
        mon(1, out_valid_b, 32'(sum_b));
        mon(2, out_valid_c, 32'(sum_c));
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic drive(input int id, input logic v, input int x[5]);
        int n, w, s;
        n = N_OF[id];
        w = W_OF[id];
        s = 0;
        for (int i = 0; i < n; i++) s += x[i] & ((1 << w) - 1);
        case (id)
            0: begin
                in_valid_a = v;
                for (int i = 0; i < 4; i++) ops_a[i*8 +: 8] = 8'(x[i]);
            end
            1: begin
                in_valid_b = v;
                for (int i = 0; i < 3; i++) ops_b[i*8 +: 8] = 8'(x[i]);
            end
            default: begin
                in_valid_c = v;
                for (int i = 0; i < 5; i++) ops_c[i*6 +: 6] = 6'(x[i]);
            end
        endcase
        if (v && !reset) q[id].push_back('{sum: s, due: cyc + 1 + LV_OF[id]});
    endtask

    task automatic drive_vals(input int id, input int a0, input int a1, input int a2,
                              input int a3, input int a4);
        int x[5];
        x = '{a0, a1, a2, a3, a4};
        drive(id, 1'b1, x);
    endtask

    task automatic drive_rand(input int id, input logic v);
        int x[5];
        for (int i = 0; i < 5; i++) x[i] = int'($urandom_range(0, (1 << W_OF[id]) - 1));
        drive(id, v, x);
    endtask

    task automatic idle(input int n);
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_valid_c = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset held two cycles with random valid operands: all must be dropped.
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int id = 0; id < 3; id++) drive_rand(id, 1'b1);
            tick();
        end
        reset = 1'b0;
        idle(3);

        // Maximum operands on every instance, then hold through idle cycles.
        drive_vals(0, 255, 255, 255, 255, 0);
        drive_vals(1, 255, 255, 255, 0, 0);
        drive_vals(2, 63, 63, 63, 63, 63);
        tick();
        idle(7);

        // Back-to-back stream plus the odd-count case.
        drive_vals(0, 1, 2, 3, 4, 0);
        drive_vals(1, 200, 100, 50, 0, 0);
        drive_vals(2, 1, 2, 3, 4, 5);
        tick();
        drive_vals(0, 10, 20, 30, 40, 0);
        in_valid_b = 1'b0;
        in_valid_c = 1'b0;
        tick();
        drive_vals(0, 0, 0, 0, 0, 0);
        tick();
        idle(5);

        // Bubble then a reset while 28 is still in flight.
        drive_vals(0, 5, 5, 5, 5, 0);
        tick();
        in_valid_a = 1'b0;
        tick();
        drive_vals(0, 7, 7, 7, 7, 0);
        tick();
        in_valid_a = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(5);

`ifdef ACCUM_EN
        // Accumulator: five 1020 results wrap at 2^12, then clear-with-add.
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_vals(0, 255, 255, 255, 255, 0);
            tick();
        end
        idle(4);
        check("acc_wrap", 64'(acc_a), 64'(1004));
        drive_vals(0, 1, 2, 3, 4, 0);
        tick();
        idle(2);
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        check("acc_clear_add", 64'(acc_a), 64'(10));
        idle(3);
`endif

        // Randomized traffic with occasional resets and accumulator clears.
        for (int k = 0; k < 300; k++) begin
            reset     = ($urandom_range(0, 49) == 0);
            acc_clear = ($urandom_range(0, 7) == 0);
            for (int id = 0; id < 3; id++) drive_rand(id, $urandom_range(0, 9) < 7);
            tick();
        end
        reset     = 1'b0;
        acc_clear = 1'b0;
        idle(8);

        for (int id = 0; id < 3; id++)
            check($sformatf("drain[%0d]", id), 64'(q[id].size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
